// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-controller / backing-store request interface.
// Both the cache controller and the responder import this package so that the
// state encoding and the read/write code point stay in one place.
package mem_if_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Encoding of the rw request bit.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Width of a counter that must hold values 0..max_val, never narrower than 1 bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = (max_val > 0) ? $clog2(max_val + 1) : 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/backing_mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// backing-store responder (slave). Four-phase req/ack: req stays high until ack
// is seen, ack stays high until req falls.
interface backing_mem_responder_if #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
);
  logic               enab;
  logic               req;
  logic               rw;
  logic [A_WIDTH-1:0] Addr;
  logic [D_WIDTH-1:0] data_in;
  logic               ack;
  logic [D_WIDTH-1:0] data_out;
  logic               err;
  logic               busy;

  modport master (
    output enab, req, rw, Addr, data_in,
    input  ack, data_out, err, busy
  );

  modport slave (
    input  enab, req, rw, Addr, data_in,
    output ack, data_out, err, busy
  );
endinterface

// File: rtl/backing_mem_responder_word_array.sv
// DEPTH x D_WIDTH storage for the backing-store responder. One synchronous
// write port, one asynchronous read port; the whole array clears on reset so a
// freshly reset memory reads back as zero.
module backing_mem_responder_word_array #(
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem_r [DEPTH];

  // Storage update: clear every word on reset, otherwise accept one write per cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {D_WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Asynchronous read; the caller only presents indices that passed the range check.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/backing_mem_responder.sv
// Backing-store responder below the cache. Accepts one single-word read or write
// at a time over a 4-phase req/ack handshake, inserts LATENCY wait states to
// model slow main memory, and flags addresses beyond the implemented DEPTH.
// Request fields are captured on the acceptance edge; later changes on the bus
// do not affect the access.
module backing_mem_responder
  import mem_if_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic clr,
  backing_mem_responder_if.slave bus
);

  localparam int CNT_W = cnt_width(LATENCY);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_t         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               rw_r;
  logic [A_WIDTH-1:0] addr_r;
  logic [D_WIDTH-1:0] wdata_r;
  logic               ack_r;
  logic               err_r;
  logic               busy_r;
  logic [D_WIDTH-1:0] dout_r;

  logic               in_range_s;
  logic               access_s;
  logic               we_s;
  logic [IDX_W-1:0]   idx_s;
  logic [D_WIDTH-1:0] rdata_s;

  // Decode of the captured request: range check first, index from the low bits only after it.
  always_comb begin
    in_range_s = (32'(addr_r) < 32'(DEPTH));
    idx_s      = addr_r[IDX_W-1:0];
    access_s   = 1'b0;
    if ((state_r == ST_WAIT) && bus.req && (cnt_r == CNT_ZERO)) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
    we_s = access_s && (rw_r == RW_WRITE) && in_range_s;
  end

  backing_mem_responder_word_array #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W)
  ) u_word_array (
    .clk   (clk),
    .clr   (clr),
    .we    (we_s),
    .waddr (idx_s),
    .wdata (wdata_r),
    .raddr (idx_s),
    .rdata (rdata_s)
  );

  // Handshake FSM with wait-state counter, request capture and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      rw_r    <= RW_READ;
      addr_r  <= {A_WIDTH{1'b0}};
      wdata_r <= {D_WIDTH{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      dout_r  <= {D_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.enab && bus.req) begin
            rw_r    <= bus.rw;
            addr_r  <= bus.Addr;
            wdata_r <= bus.data_in;
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
            state_r <= ST_WAIT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!bus.req) begin
            // Cache withdrew the request: abandon it without touching memory.
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            ack_r   <= 1'b1;
            err_r   <= !in_range_s;
            if (rw_r == RW_READ) begin
              dout_r <= in_range_s ? rdata_s : {D_WIDTH{1'b0}};
            end else begin
              dout_r <= dout_r;
            end
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!bus.req) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack_r;
  assign bus.err      = err_r;
  assign bus.busy     = busy_r;
  assign bus.data_out = dout_r;

endmodule

// File: tb/tb_backing_mem_responder.sv
// Self-checking bench for backing_mem_responder. Two instances share clock and
// reset: one with LATENCY=2 (index 0) and one with LATENCY=0 (index 1). A small
// memory model predicts data_out/err; predictions are queued when a request is
// driven and popped when ack appears.
module tb_backing_mem_responder;

  logic clk;
  logic clr;

  backing_mem_responder_if #(.D_WIDTH(8), .A_WIDTH(8)) bus2 ();
  backing_mem_responder_if #(.D_WIDTH(8), .A_WIDTH(8)) bus0 ();

  backing_mem_responder #(.D_WIDTH(8), .A_WIDTH(8), .DEPTH(16), .LATENCY(2)) dut2 (
    .clk (clk),
    .clr (clr),
    .bus (bus2.slave)
  );

  backing_mem_responder #(.D_WIDTH(8), .A_WIDTH(8), .DEPTH(16), .LATENCY(0)) dut0 (
    .clk (clk),
    .clr (clr),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m2 [16];
  logic [7:0] m0 [16];
  logic [7:0] dm2;
  logic [7:0] dm0;
  logic [7:0] exp_data_q [$];
  logic       exp_err_q  [$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ack_of(input bit sel);
    return sel ? bus0.ack : bus2.ack;
  endfunction

  function automatic logic err_of(input bit sel);
    return sel ? bus0.err : bus2.err;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? bus0.busy : bus2.busy;
  endfunction

  function automatic logic [7:0] dout_of(input bit sel);
    return sel ? bus0.data_out : bus2.data_out;
  endfunction

  task automatic drive(input bit sel, input logic en, input logic rq, input logic rw,
                       input logic [7:0] addr, input logic [7:0] wd);
    if (sel) begin
      bus0.enab = en; bus0.req = rq; bus0.rw = rw; bus0.Addr = addr; bus0.data_in = wd;
    end else begin
      bus2.enab = en; bus2.req = rq; bus2.rw = rw; bus2.Addr = addr; bus2.data_in = wd;
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      m2[i] = 8'h00;
      m0[i] = 8'h00;
    end
    dm2 = 8'h00;
    dm0 = 8'h00;
  endtask

  // Predict the response of one request and update the model as the DUT should.
  task automatic predict(input bit sel, input logic rw, input logic [7:0] addr, input logic [7:0] wd);
    bit in_rng;
    logic [7:0] d;
    in_rng = (addr < 8'd16);
    d = sel ? dm0 : dm2;
    if (rw == 1'b0) begin
      if (in_rng) d = sel ? m0[addr[3:0]] : m2[addr[3:0]];
      else        d = 8'h00;
    end else if (in_rng) begin
      if (sel) m0[addr[3:0]] = wd;
      else     m2[addr[3:0]] = wd;
    end
    if (sel) dm0 = d;
    else     dm2 = d;
    exp_data_q.push_back(d);
    exp_err_q.push_back(!in_rng);
  endtask

  // Full transaction; optionally scramble the bus (and drop enab) after acceptance.
  task automatic txn(input bit sel, input logic rw, input logic [7:0] addr,
                     input logic [7:0] wd, input bit mutate, input string tag);
    int lat;
    int n;
    bit got;
    logic [7:0] ed;
    logic ee;
    lat = sel ? 0 : 2;
    @(negedge clk);
    drive(sel, 1'b1, 1'b1, rw, addr, wd);
    predict(sel, rw, addr, wd);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      n++;
      if (ack_of(sel)) got = 1'b1;
      else if (mutate && n == 1) drive(sel, 1'b0, 1'b1, ~rw, addr ^ 8'h03, ~wd);
    end
    ed = exp_data_q.pop_front();
    ee = exp_err_q.pop_front();
    check_value({tag, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      check_value({tag, "_lat"}, 32'(n), 32'(lat + 2));
      check_value({tag, "_dout"}, 32'(dout_of(sel)), 32'(ed));
      check_value({tag, "_err"}, 32'(err_of(sel)), 32'(ee));
      check_value({tag, "_busy"}, 32'(busy_of(sel)), 32'd1);
      @(posedge clk); #1;
      check_value({tag, "_ack_held"}, 32'(ack_of(sel)), 32'd1);
      check_value({tag, "_dout_held"}, 32'(dout_of(sel)), 32'(ed));
    end
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, rw, addr, wd);
    @(posedge clk); #1;
    check_value({tag, "_ack_fall"}, 32'(ack_of(sel)), 32'd0);
    check_value({tag, "_err_fall"}, 32'(err_of(sel)), 32'd0);
    check_value({tag, "_idle"}, 32'(busy_of(sel)), 32'd0);
  endtask

  initial begin
    clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_ack", 32'(bus2.ack), 32'd0);
    check_value("rst_err", 32'(bus2.err), 32'd0);
    check_value("rst_busy", 32'(bus2.busy), 32'd0);
    check_value("rst_dout", 32'(bus2.data_out), 32'd0);
    check_value("rst_busy0", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Write then read back with two wait states.
    txn(1'b0, 1'b1, 8'h05, 8'hA5, 1'b0, "wr5");
    txn(1'b0, 1'b0, 8'h05, 8'h00, 1'b0, "rd5");

    // Zero-latency instance.
    txn(1'b1, 1'b1, 8'h00, 8'h11, 1'b0, "l0_wr0");
    txn(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "l0_rd0");

    // Out-of-range accesses must not disturb in-range contents.
    txn(1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, "wr0");
    txn(1'b0, 1'b1, 8'h20, 8'hFF, 1'b0, "oor_wr");
    txn(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, "oor_rd");
    txn(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "rd0");
    txn(1'b0, 1'b0, 8'h0F, 8'h00, 1'b0, "rd15");

    // Request withdrawn during wait states: no ack, memory untouched.
    txn(1'b0, 1'b1, 8'h07, 8'h22, 1'b0, "wr7");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 8'h77);
    @(posedge clk); #1;
    check_value("abort_busy", 32'(bus2.busy), 32'd1);
    @(negedge clk);
    bus2.req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_value("abort_noack", 32'(bus2.ack), 32'd0);
      check_value("abort_idle", 32'(bus2.busy), 32'd0);
    end
    txn(1'b0, 1'b0, 8'h07, 8'h00, 1'b0, "rd7");

    // Disabled responder ignores requests.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 8'hEE);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_value("dis_busy", 32'(bus2.busy), 32'd0);
      check_value("dis_ack", 32'(bus2.ack), 32'd0);
    end
    @(negedge clk);
    bus2.req = 1'b0;
    @(posedge clk);

    // Bus changes (and enab drop) after acceptance do not affect the access.
    txn(1'b0, 1'b1, 8'h09, 8'h99, 1'b1, "mut_wr9");
    txn(1'b0, 1'b0, 8'h09, 8'h00, 1'b0, "rd9");
    txn(1'b0, 1'b0, 8'h0A, 8'h00, 1'b0, "rd10");
    txn(1'b1, 1'b0, 8'h0C, 8'h00, 1'b1, "l0_mut_rd12");

    // Reset in the middle of a write aborts it and clears memory.
    txn(1'b0, 1'b1, 8'h03, 8'h3A, 1'b0, "wr3");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h5A);
    @(posedge clk); #1;
    check_value("mid_busy", 32'(bus2.busy), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    #1;
    clear_models();
    check_value("mid_rst_ack", 32'(bus2.ack), 32'd0);
    check_value("mid_rst_busy", 32'(bus2.busy), 32'd0);
    @(negedge clk);
    bus2.req = 1'b0;
    clr = 1'b1;
    txn(1'b0, 1'b0, 8'h03, 8'h00, 1'b0, "rd3_after_rst");
    txn(1'b0, 1'b0, 8'h05, 8'h00, 1'b0, "rd5_after_rst");
    txn(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "l0_rd0_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
